// File: rtl/i2c_eeprom_slave_if.sv
// i2c_eeprom_slave_if: I2C pair plus the memory-commit strobe of the EEPROM responder.
interface i2c_eeprom_slave_if #(
   parameter int MEM_AW = 11
);
   logic              SCL;
   wire               SDA;
   logic              BUSY;
   logic              WR_STB;
   logic [MEM_AW-1:0] MEM_ADDR;
   logic [7:0]        MEM_WDATA;
   pullup (SDA);
   modport slave (input SCL, inout SDA, output BUSY, WR_STB, MEM_ADDR, MEM_WDATA);
   modport master (output SCL, inout SDA, input BUSY, WR_STB, MEM_ADDR, MEM_WDATA);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: oversampled I2C target emulating a 24C16-class EEPROM with internal byte storage.
module i2c_eeprom_slave #(
   parameter logic [3:0] DEV_CODE = 4'b1010,
   parameter int         MEM_AW   = 11
) (
   input logic               CLK,
   input logic               RESET_N,
   i2c_eeprom_slave_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;
   state_t            state, state_nxt;
   logic [1:0]        scl_sync, sda_sync;
   logic              scl_hist, sda_hist;
   logic              scl_rise, scl_fall, start_det, stop_det, sda_in;
   logic [7:0]        mem [2**MEM_AW];
   logic [MEM_AW-1:0] ptr, ptr_nxt, wr_addr, wr_addr_nxt;
   logic [6:0]        sreg, sreg_nxt;
   logic [7:0]        byte_in, rd_byte, wr_data, wr_data_nxt;
   logic [10:0]       full_addr;
   logic [2:0]        hi, hi_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              ph, ph_nxt, sda_oe, sda_oe_nxt, busy, busy_nxt, wr_stb, wr_stb_nxt;
   // Synchronizers idle high so reset release never fakes a START/STOP.
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], bus.SCL};
         sda_sync <= {sda_sync[0], bus.SDA};
         scl_hist <= scl_sync[1];
         sda_hist <= sda_sync[1];
      end
   assign sda_in    = sda_sync[1];
   assign scl_rise  = scl_sync[1] & ~scl_hist;
   assign scl_fall  = ~scl_sync[1] & scl_hist;
   assign start_det = scl_sync[1] & scl_hist & sda_hist & ~sda_in;
   assign stop_det  = scl_sync[1] & scl_hist & ~sda_hist & sda_in;
   assign byte_in   = {sreg, sda_in};
   assign full_addr = {hi, byte_in};
   assign rd_byte   = mem[ptr];
   // ph marks the second half of an ACK slot; in RDATA_ACK it records the master's ACK.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      sreg_nxt    = sreg;
      hi_nxt      = hi;
      cnt_nxt     = cnt;
      ph_nxt      = ph;
      sda_oe_nxt  = sda_oe;
      busy_nxt    = busy;
      wr_stb_nxt  = 1'b0;
      wr_addr_nxt = wr_addr;
      wr_data_nxt = wr_data;
      if (stop_det) begin
         state_nxt  = IDLE;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
      end else if (start_det) begin
         state_nxt  = CTRL;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
         cnt_nxt    = 4'd0;
      end else if (scl_rise && sda_oe && sda_in) begin
         state_nxt  = IDLE;
         sda_oe_nxt = 1'b0;
      end else begin
         case (state)
            CTRL: if (scl_rise) begin
               sreg_nxt = byte_in[6:0];
               cnt_nxt  = cnt + 4'd1;
               ph_nxt   = 1'b0;
               if (cnt == 4'd7) begin
                  state_nxt = byte_in[7:4] == DEV_CODE ? CTRL_ACK : IDLE;
                  busy_nxt  = byte_in[7:4] == DEV_CODE;
                  hi_nxt    = byte_in[3:1];
               end
            end
            ADDR: if (scl_rise) begin
               sreg_nxt = byte_in[6:0];
               cnt_nxt  = cnt + 4'd1;
               ph_nxt   = 1'b0;
               if (cnt == 4'd7) begin
                  ptr_nxt   = full_addr[MEM_AW-1:0];
                  state_nxt = ADDR_ACK;
               end
            end
            WDATA: if (scl_rise) begin
               sreg_nxt = byte_in[6:0];
               cnt_nxt  = cnt + 4'd1;
               ph_nxt   = 1'b0;
               if (cnt == 4'd7) begin
                  wr_stb_nxt  = 1'b1;
                  wr_addr_nxt = ptr;
                  wr_data_nxt = byte_in;
                  ptr_nxt     = ptr + MEM_AW'(1);
                  state_nxt   = WDATA_ACK;
               end
            end
            CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) begin
               sda_oe_nxt = ~ph;
               ph_nxt     = 1'b1;
               cnt_nxt    = 4'd0;
               if (ph) begin
                  state_nxt = state == CTRL_ACK ? (sreg[0] ? RDATA : ADDR) : WDATA;
                  if (state == CTRL_ACK && sreg[0]) begin
                     sreg_nxt   = rd_byte[6:0];
                     sda_oe_nxt = ~rd_byte[7];
                  end
               end
            end
            RDATA: begin
               if (scl_rise) cnt_nxt = cnt + 4'd1;
               if (scl_fall) begin
                  if (cnt == 4'd8) begin
                     sda_oe_nxt = 1'b0;
                     ptr_nxt    = ptr + MEM_AW'(1);
                     ph_nxt     = 1'b0;
                     state_nxt  = RDATA_ACK;
                  end else begin
                     sreg_nxt   = {sreg[5:0], 1'b0};
                     sda_oe_nxt = ~sreg[6];
                  end
               end
            end
            RDATA_ACK: begin
               if (scl_rise) begin
                  state_nxt = sda_in ? IDLE : RDATA_ACK;
                  ph_nxt    = ~sda_in;
               end
               if (scl_fall && ph) begin
                  state_nxt  = RDATA;
                  sreg_nxt   = rd_byte[6:0];
                  sda_oe_nxt = ~rd_byte[7];
                  cnt_nxt    = 4'd0;
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         state   <= IDLE;
         ptr     <= '0;
         sreg    <= '0;
         hi      <= '0;
         cnt     <= '0;
         ph      <= 1'b0;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         wr_stb  <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         sreg    <= sreg_nxt;
         hi      <= hi_nxt;
         cnt     <= cnt_nxt;
         ph      <= ph_nxt;
         sda_oe  <= sda_oe_nxt;
         busy    <= busy_nxt;
         wr_stb  <= wr_stb_nxt;
         wr_addr <= wr_addr_nxt;
         wr_data <= wr_data_nxt;
      end
   always_ff @(posedge CLK)
      if (wr_stb) mem[wr_addr] <= wr_data;
   assign bus.SDA       = sda_oe ? 1'b0 : 1'bz;
   assign bus.BUSY      = busy;
   assign bus.WR_STB    = wr_stb;
   assign bus.MEM_ADDR  = wr_addr;
   assign bus.MEM_WDATA = wr_data;
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: directed I2C master transactions against the EEPROM responder.
module tb_i2c_eeprom_slave;
   localparam int Q = 100;
   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        scl = 1'b1;
   logic        m_oe = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          wr_cnt = 0;
   logic [10:0] wa_log [0:15];
   logic [7:0]  wd_log [0:15];
   logic        ack, r;
   logic [7:0]  rd;
   logic [3:0]  nib;
   i2c_eeprom_slave_if #(.MEM_AW(11)) bus ();
   assign bus.SCL = scl;
   assign bus.SDA = m_oe ? 1'b0 : 1'bz;
   i2c_eeprom_slave #(.DEV_CODE(4'b1010), .MEM_AW(11)) dut (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .bus(bus)
   );
   always #5 CLK = ~CLK;
   always @(negedge CLK)
      if (bus.WR_STB === 1'b1) begin
         wa_log[wr_cnt % 16] = bus.MEM_ADDR;
         wd_log[wr_cnt % 16] = bus.MEM_WDATA;
         wr_cnt++;
      end
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic i2c_start;
      m_oe = 1'b0; #Q;
      scl = 1'b1;  #Q;
      m_oe = 1'b1; #Q;
      scl = 1'b0;  #Q;
   endtask
   task automatic i2c_stop;
      m_oe = 1'b1; #Q;
      scl = 1'b1;  #Q;
      m_oe = 1'b0; #Q;
   endtask
   task automatic xbit(input logic b, output logic s);
      m_oe = ~b;  #Q;
      scl = 1'b1; #Q;
      s = bus.SDA; #Q;
      scl = 1'b0; #Q;
   endtask
   task automatic send_byte(input logic [7:0] d, output logic a);
      logic s;
      for (int i = 7; i >= 0; i--) xbit(d[i], s);
      xbit(1'b1, a);
   endtask
   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         xbit(1'b1, s);
         d[i] = s;
      end
      xbit(nack, s);
   endtask
   initial begin
      #20;
      check("rst_sda", 16'(bus.SDA), 16'h1);
      check("rst_busy", 16'(bus.BUSY), 16'h0);
      check("rst_wr_stb", 16'(bus.WR_STB), 16'h0);
      check("rst_addr", 16'(bus.MEM_ADDR), 16'h0);
      check("rst_wdata", 16'(bus.MEM_WDATA), 16'h0);
      #30 RESET_N = 1'b1;
      #50;
      // T1: single byte write to 0x123
      i2c_start;
      send_byte(8'hA2, ack); check("t1_ctrl_ack", 16'(ack), 16'h0);
      check("t1_busy", 16'(bus.BUSY), 16'h1);
      send_byte(8'h23, ack); check("t1_addr_ack", 16'(ack), 16'h0);
      send_byte(8'h5A, ack); check("t1_data_ack", 16'(ack), 16'h0);
      i2c_stop;
      check("t1_busy_stop", 16'(bus.BUSY), 16'h0);
      check("t1_wr_cnt", 16'(wr_cnt), 16'd1);
      check("t1_wr_addr", 16'(wa_log[0]), 16'h123);
      check("t1_wr_data", 16'(wd_log[0]), 16'h5A);
      // T2: random read of 0x123
      i2c_start;
      send_byte(8'hA2, ack); check("t2_ctrl_ack", 16'(ack), 16'h0);
      send_byte(8'h23, ack); check("t2_addr_ack", 16'(ack), 16'h0);
      i2c_start;
      send_byte(8'hA3, ack); check("t2_rd_ack", 16'(ack), 16'h0);
      recv_byte(1'b1, rd); check("t2_rdata", 16'(rd), 16'h5A);
      check("t2_busy", 16'(bus.BUSY), 16'h1);
      i2c_stop;
      check("t2_busy_stop", 16'(bus.BUSY), 16'h0);
      check("t2_wr_cnt", 16'(wr_cnt), 16'd1);
      // T3: wrong device code
      i2c_start;
      send_byte(8'h92, ack); check("t3_nack", 16'(ack), 16'h1);
      check("t3_busy", 16'(bus.BUSY), 16'h0);
      send_byte(8'h00, ack); check("t3_ignored", 16'(ack), 16'h1);
      i2c_stop;
      check("t3_wr_cnt", 16'(wr_cnt), 16'd1);
      // T4: sequential write across the top of memory, then sequential read
      i2c_start;
      send_byte(8'hAE, ack); check("t4_ctrl_ack", 16'(ack), 16'h0);
      send_byte(8'hFF, ack); check("t4_addr_ack", 16'(ack), 16'h0);
      send_byte(8'h11, ack); check("t4_d0_ack", 16'(ack), 16'h0);
      send_byte(8'h22, ack); check("t4_d1_ack", 16'(ack), 16'h0);
      i2c_stop;
      check("t4_wr_cnt", 16'(wr_cnt), 16'd3);
      check("t4_wr_addr0", 16'(wa_log[1]), 16'h7FF);
      check("t4_wr_data0", 16'(wd_log[1]), 16'h11);
      check("t4_wr_addr1", 16'(wa_log[2]), 16'h000);
      check("t4_wr_data1", 16'(wd_log[2]), 16'h22);
      i2c_start;
      send_byte(8'hAE, ack);
      send_byte(8'hFF, ack);
      i2c_start;
      send_byte(8'hAF, ack); check("t4_rd_ack", 16'(ack), 16'h0);
      recv_byte(1'b0, rd); check("t4_rd0", 16'(rd), 16'h11);
      recv_byte(1'b1, rd); check("t4_rd1", 16'(rd), 16'h22);
      i2c_stop;
      // T5: aborted partial byte leaves memory untouched
      i2c_start;
      send_byte(8'hA0, ack);
      send_byte(8'h10, ack);
      send_byte(8'h77, ack); check("t5_pre_ack", 16'(ack), 16'h0);
      i2c_stop;
      check("t5_pre_cnt", 16'(wr_cnt), 16'd4);
      check("t5_pre_addr", 16'(wa_log[3]), 16'h010);
      i2c_start;
      send_byte(8'hA0, ack);
      send_byte(8'h10, ack);
      xbit(1'b1, r); xbit(1'b0, r); xbit(1'b1, r); xbit(1'b0, r);
      i2c_stop;
      check("t5_no_wr", 16'(wr_cnt), 16'd4);
      i2c_start;
      send_byte(8'hA0, ack);
      send_byte(8'h10, ack);
      i2c_start;
      send_byte(8'hA1, ack);
      recv_byte(1'b1, rd); check("t5_rd", 16'(rd), 16'h77);
      i2c_stop;
      // T6: reset while the responder drives bit 3 of 0x77 low
      i2c_start;
      send_byte(8'hA0, ack);
      send_byte(8'h10, ack);
      i2c_start;
      send_byte(8'hA1, ack);
      for (int i = 3; i >= 0; i--) begin
         xbit(1'b1, r);
         nib[i] = r;
      end
      check("t6_nibble", 16'(nib), 16'h7);
      m_oe = 1'b0; #Q;
      scl = 1'b1;  #Q;
      check("t6_sda_driven", 16'(bus.SDA), 16'h0);
      RESET_N = 1'b0;
      #10;
      check("t6_sda_rel", 16'(bus.SDA), 16'h1);
      check("t6_busy", 16'(bus.BUSY), 16'h0);
      #50 RESET_N = 1'b1;
      #50;
      i2c_start;
      send_byte(8'hA1, ack); check("t6_cur_ack", 16'(ack), 16'h0);
      recv_byte(1'b1, rd); check("t6_cur_rd", 16'(rd), 16'h22);
      i2c_stop;
      check("t6_wr_cnt", 16'(wr_cnt), 16'd4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
